ext_mem_responder: RTL and testbench
====================================

Name: ext_mem_responder

Overview:
- Responder (target) end of the external memory bus that the CPU block drives with its outbound address/data, read_q/write_q strobes and rw_halt, and that it closes with read_dn/write_dn.
- Holds a word-addressed synchronous RAM window at BASE_ADDR, serves reads and writes with a programmable wait-state count, and honours bus halt.
- All outputs are zero whenever the responder is not answering, so several responders can share the OR-combined return bus.

Parameters:
ADDR_SIZE, 32, address bus width
DATA_SIZE, 32, data bus width
MEM_DEPTH_LOG2, 10, log2 of word count; window = BASE_ADDR .. BASE_ADDR + 2^MEM_DEPTH_LOG2 - 1
BASE_ADDR, 32'h0000_1000, first word address served
WAIT_STATES, 2, extra cycles between request accept and dn assertion (0..15)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  asynchronous, active-high reset
addr_in  in  ADDR_SIZE  request address (initiator addr_out)
data_in  in  DATA_SIZE  write data (initiator data_out)
read_q  in  1  read request, level, held until dn seen
write_q  in  1  write request, level, held until dn seen
rw_halt  in  1  bus halt: freezes wait-state progress
addr_out  out  ADDR_SIZE  echo of accepted address while read_dn/write_dn high, else 0
data_out  out  DATA_SIZE  read data while read_dn high, else 0
read_dn  out  1  read complete
write_dn  out  1  write complete
busy  out  1  high in any state other than IDLE
err  out  1  one-cycle pulse on a protocol error

Behaviour:
- Reset (async assert, sync release): state=IDLE; every output 0; wait counter 0. RAM contents are not cleared.
- States:
  - IDLE: a request is accepted on an edge where all of the following hold: exactly one of read_q/write_q is high, addr_in is in the window, and rw_halt=0.
  - On accept: latch the address, latch data_in (for a write), load counter=WAIT_STATES, go to WAIT.
  - An out-of-range address is ignored and the FSM stays in IDLE. No output toggles, because another responder owns that address.
- WAIT:
  - Counter decrements each cycle rw_halt=0 and holds while rw_halt=1.
  - Reaching 0 with rw_halt=0 moves to DN_RD or DN_WR.
  - Latency: dn first high at accept edge + WAIT_STATES + 1 cycles when there is no halt. With WAIT_STATES=0, dn is high the cycle after accept.
  - The RAM read is issued during WAIT, so data is registered on entry to DN_RD.
- DN_RD: read_dn=1, data_out=RAM[latched addr - BASE_ADDR], addr_out=latched addr.
- DN_WR: RAM written with the latched data on the entry edge; write_dn=1, addr_out=latched addr.
- DN states are held (four-phase handshake) until the active q is sampled low. dn deasserts on the next edge and the FSM returns to IDLE. rw_halt is ignored in DN states.
- Back-to-back requests: a new request is accepted no earlier than the edge after IDLE is re-entered. Minimum period = WAIT_STATES + 3 cycles.
- Abort: if the latched q drops while in WAIT, go to IDLE with no RAM write and no dn.
- Protocol errors:
  - read_q and write_q both high in IDLE with an in-range address: no accept, err pulses for 1 cycle.
  - The opposite q rising during WAIT or DN: err pulses, the current transaction continues.
- Address, data and write data are latched at accept; later changes on addr_in/data_in have no effect on the transaction.
- RAM index = (addr - BASE_ADDR) truncated to MEM_DEPTH_LOG2 bits. In-range compare is an unsigned full ADDR_SIZE compare against both bounds, with no wrap-around.
- Reset asserted mid-transaction: immediate return to IDLE, outputs 0.
  - A write already committed on the DN_WR entry edge persists.
  - A write still in WAIT is dropped.

Test Plan:
- Write 0xDEADBEEF to 0x1005 (WAIT_STATES=2, no halt), then read 0x1005 -> write_dn rises 3 cycles after accept; read_dn rises 3 cycles after accept with data_out=0xDEADBEEF and addr_out=0x1005; both dn drop 1 cycle after q drops; outputs 0 otherwise.
- Read 0x0FFF and 0x1400 -> no dn, busy stays 0, all outputs 0 for 20 cycles. Read 0x13FF -> served.
- Read 0x1005 with rw_halt high for 4 cycles during WAIT -> read_dn rises at accept+7; with rw_halt high in IDLE, no accept until rw_halt falls.
- read_q and write_q both high at 0x1000 -> err is a single-cycle pulse, no dn. Write at 0x1001 with write_q dropped after 1 WAIT cycle -> no write_dn; a subsequent read of 0x1001 returns the old value.
- Reset pulsed during WAIT of a write to 0x1002 -> outputs 0 immediately, RAM[2] unchanged. A previously written RAM[5]=0xDEADBEEF survives reset.
- WAIT_STATES=0 back-to-back reads of 0x1000 and 0x1001, q dropped the cycle dn is seen -> each dn is high 1 cycle after accept; accepts are 3 cycles apart.

Source files
------------

// File: rtl/ext_mem_responder.sv
// ext_mem_responder: target end of the external memory bus.
// Serves a word-addressed RAM window with wait states, bus halt and abort.
module ext_mem_responder #(
    parameter int                   ADDR_SIZE      = 32,
    parameter int                   DATA_SIZE      = 32,
    parameter int                   MEM_DEPTH_LOG2 = 10,
    parameter logic [ADDR_SIZE-1:0] BASE_ADDR      = 'h1000,
    parameter int                   WAIT_STATES    = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [ADDR_SIZE-1:0] addr_in,
    input  logic [DATA_SIZE-1:0] data_in,
    input  logic                 read_q,
    input  logic                 write_q,
    input  logic                 rw_halt,
    output logic [ADDR_SIZE-1:0] addr_out,
    output logic [DATA_SIZE-1:0] data_out,
    output logic                 read_dn,
    output logic                 write_dn,
    output logic                 busy,
    output logic                 err
);

    localparam int DEPTH = 1 << MEM_DEPTH_LOG2;

    // One extra bit so the upper window bound can never wrap.
    typedef logic [ADDR_SIZE:0] wide_t;
    localparam wide_t LO = wide_t'(BASE_ADDR);
    localparam wide_t HI = LO + wide_t'(DEPTH) - wide_t'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DN_RD,
        S_DN_WR
    } state_t;

    state_t state;
    state_t state_n;

    logic [3:0]                cnt;
    logic [3:0]                cnt_n;
    logic [ADDR_SIZE-1:0]      addr_lat;
    logic [DATA_SIZE-1:0]      data_lat;
    logic                      op_wr;
    logic                      rq_d;
    logic                      wq_d;
    logic                      both_d;
    logic                      err_r;
    logic [DATA_SIZE-1:0]      rd_data;
    logic [MEM_DEPTH_LOG2-1:0] idx;
    logic [DATA_SIZE-1:0]      mem [DEPTH];

    wide_t addr_x;
    logic  in_range;
    logic  accept;
    logic  both_err;
    logic  act_q;
    logic  opp_rise;
    logic  commit;

    assign addr_x   = {1'b0, addr_in};
    assign in_range = (addr_x >= LO) && (addr_x <= HI);
    assign accept   = (state == S_IDLE) && (read_q ^ write_q)
                      && in_range && !rw_halt;
    assign both_err = (state == S_IDLE) && read_q && write_q && in_range;
    assign act_q    = op_wr ? write_q : read_q;
    assign opp_rise = op_wr ? (read_q & ~rq_d) : (write_q & ~wq_d);
    assign idx      = MEM_DEPTH_LOG2'(addr_lat - BASE_ADDR);

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        commit  = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (accept) begin
                    state_n = S_WAIT;
                    cnt_n   = 4'(WAIT_STATES);
                end
            end
            S_WAIT: begin
                if (!act_q) begin
                    state_n = S_IDLE;
                end else if (!rw_halt) begin
                    if (cnt == '0) begin
                        state_n = op_wr ? S_DN_WR : S_DN_RD;
                        commit  = op_wr;
                    end else begin
                        cnt_n = cnt - 4'd1;
                    end
                end
            end
            S_DN_RD, S_DN_WR: begin
                if (!act_q) begin
                    state_n = S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            cnt      <= '0;
            addr_lat <= '0;
            data_lat <= '0;
            op_wr    <= 1'b0;
            rq_d     <= 1'b0;
            wq_d     <= 1'b0;
            both_d   <= 1'b0;
            err_r    <= 1'b0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            rq_d   <= read_q;
            wq_d   <= write_q;
            both_d <= both_err;
            err_r  <= (both_err & ~both_d) | (busy & opp_rise);
            if (accept) begin
                addr_lat <= addr_in;
                data_lat <= data_in;
                op_wr    <= write_q;
            end
        end
    end

    // RAM is deliberately outside reset so contents survive it.
    always_ff @(posedge clk) begin
        if (commit) begin
            mem[idx] <= data_lat;
        end
        if (state == S_WAIT) begin
            rd_data <= mem[idx];
        end
    end

    assign busy     = (state != S_IDLE);
    assign read_dn  = (state == S_DN_RD);
    assign write_dn = (state == S_DN_WR);
    assign addr_out = (read_dn || write_dn) ? addr_lat : '0;
    assign data_out = read_dn ? rd_data : '0;
    assign err      = err_r;

endmodule

// File: tb/tb_ext_mem_responder.sv
// Directed bench for ext_mem_responder: WAIT_STATES=2 main instance
// plus a WAIT_STATES=0 instance for back-to-back timing.
module tb_ext_mem_responder;

    logic        clk;
    logic        rst;
    logic [31:0] addr_in, data_in;
    logic        read_q, write_q, rw_halt;
    logic [31:0] addr_out, data_out;
    logic        read_dn, write_dn, busy, err;

    logic [31:0] f_addr_in, f_data_in;
    logic        f_read_q, f_write_q, f_rw_halt;
    logic [31:0] f_addr_out, f_data_out;
    logic        f_read_dn, f_write_dn, f_busy, f_err;

    int total = 0;
    int bad   = 0;

    ext_mem_responder #(.WAIT_STATES(2)) u_dut (
        .clk(clk), .rst(rst),
        .addr_in(addr_in), .data_in(data_in),
        .read_q(read_q), .write_q(write_q), .rw_halt(rw_halt),
        .addr_out(addr_out), .data_out(data_out),
        .read_dn(read_dn), .write_dn(write_dn),
        .busy(busy), .err(err)
    );

    ext_mem_responder #(.WAIT_STATES(0)) u_fast (
        .clk(clk), .rst(rst),
        .addr_in(f_addr_in), .data_in(f_data_in),
        .read_q(f_read_q), .write_q(f_write_q), .rw_halt(f_rw_halt),
        .addr_out(f_addr_out), .data_out(f_data_out),
        .read_dn(f_read_dn), .write_dn(f_write_dn),
        .busy(f_busy), .err(f_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $display("FAIL %s: observed=%h expected=%h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    // Negedges from the call until the selected dn is seen (bounded).
    task automatic wait_dn(input logic wr, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(wr ? write_dn : read_dn) && n < 40);
    endtask

    task automatic xfer(input logic wr, input logic [31:0] a,
                        input logic [31:0] d, output int lat,
                        output logic [31:0] rd, output logic [31:0] ae,
                        output logic dn_after);
        read_q  = !wr;
        write_q = wr;
        addr_in = a;
        data_in = d;
        wait_dn(wr, lat);
        rd      = data_out;
        ae      = addr_out;
        read_q  = 1'b0;
        write_q = 1'b0;
        @(negedge clk);
        dn_after = read_dn | write_dn;
    endtask

    initial begin
        int          n;
        logic [31:0] rd, ae;
        logic        dn_after, seen;

        rst = 1'b1;
        addr_in = '0; data_in = '0;
        read_q = 0; write_q = 0; rw_halt = 0;
        f_addr_in = '0; f_data_in = '0;
        f_read_q = 0; f_write_q = 0; f_rw_halt = 0;
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_rdn", read_dn, 0);
        chk("rst_wdn", write_dn, 0);
        chk("rst_addr", addr_out, 0);
        chk("rst_data", data_out, 0);
        chk("rst_err", err, 0);
        chk("rst_fbusy", f_busy, 0);
        rst = 1'b0;
        @(negedge clk);

        // Write 0x1005; change inputs mid-WAIT to prove latching
        write_q = 1; addr_in = 32'h1005; data_in = 32'hDEADBEEF;
        @(negedge clk);
        chk("wr_busy", busy, 1);
        chk("wr_dn_early", write_dn, 0);
        addr_in = 32'h1006; data_in = 32'h0;
        wait_dn(1, n);
        chk("wr_lat", n, 3);
        chk("wr_addr", addr_out, 32'h1005);
        chk("wr_data0", data_out, 0);
        write_q = 0;
        @(negedge clk);
        chk("wr_dn_drop", write_dn, 0);
        chk("wr_idle", busy, 0);
        chk("wr_addr0", addr_out, 0);

        // Read back, hold q one extra cycle
        read_q = 1; addr_in = 32'h1005;
        wait_dn(0, n);
        chk("rd_lat", n, 4);
        chk("rd_data", data_out, 32'hDEADBEEF);
        chk("rd_addr", addr_out, 32'h1005);
        @(negedge clk);
        chk("rd_hold", read_dn, 1);
        read_q = 0;
        @(negedge clk);
        chk("rd_dn_drop", read_dn, 0);
        chk("rd_data0", data_out, 0);

        // Out of range below and above the window
        read_q = 1; addr_in = 32'h0FFF; seen = 0;
        repeat (20) begin
            @(negedge clk);
            seen = seen | busy | read_dn | write_dn | err
                   | (|addr_out) | (|data_out);
        end
        chk("oor_low", seen, 0);
        addr_in = 32'h1400; seen = 0;
        repeat (20) begin
            @(negedge clk);
            seen = seen | busy | read_dn | write_dn | err
                   | (|addr_out) | (|data_out);
        end
        read_q = 0;
        chk("oor_high", seen, 0);
        @(negedge clk);

        // Top word of the window
        xfer(1, 32'h13FF, 32'h12345678, n, rd, ae, dn_after);
        chk("top_wr_lat", n, 4);
        xfer(0, 32'h13FF, 0, n, rd, ae, dn_after);
        chk("top_rd_data", rd, 32'h12345678);
        chk("top_rd_addr", ae, 32'h13FF);
        chk("top_dn_drop", dn_after, 0);

        // Halt for 4 cycles during WAIT
        read_q = 1; addr_in = 32'h1005;
        @(negedge clk);
        rw_halt = 1;
        repeat (4) @(negedge clk);
        chk("halt_no_dn", read_dn, 0);
        rw_halt = 0;
        wait_dn(0, n);
        chk("halt_lat", n, 3);
        chk("halt_data", data_out, 32'hDEADBEEF);
        read_q = 0;
        @(negedge clk);

        // Halt in IDLE blocks accept
        rw_halt = 1; read_q = 1; addr_in = 32'h1005;
        repeat (3) @(negedge clk);
        chk("halt_idle", busy, 0);
        rw_halt = 0;
        wait_dn(0, n);
        chk("halt_idle_lat", n, 4);
        read_q = 0;
        @(negedge clk);

        // Both q high in IDLE: single err pulse, no accept
        read_q = 1; write_q = 1; addr_in = 32'h1000;
        @(negedge clk);
        chk("both_err1", err, 1);
        @(negedge clk);
        chk("both_err0", err, 0);
        chk("both_busy", busy, 0);
        read_q = 0; write_q = 0;
        @(negedge clk);

        // Opposite q rises during a read's WAIT
        read_q = 1; addr_in = 32'h1005;
        @(negedge clk);
        write_q = 1;
        @(negedge clk);
        chk("opp_err1", err, 1);
        write_q = 0;
        @(negedge clk);
        chk("opp_err0", err, 0);
        wait_dn(0, n);
        chk("opp_rd_lat", n, 1);
        chk("opp_rd_data", data_out, 32'hDEADBEEF);
        read_q = 0;
        @(negedge clk);

        // Abort a write after one WAIT cycle
        xfer(1, 32'h1001, 32'h11111111, n, rd, ae, dn_after);
        write_q = 1; addr_in = 32'h1001; data_in = 32'hBAD0BAD0;
        @(negedge clk);
        write_q = 0;
        @(negedge clk);
        chk("abort_idle", busy, 0);
        seen = 0;
        repeat (5) begin
            @(negedge clk);
            seen = seen | write_dn;
        end
        chk("abort_no_dn", seen, 0);
        xfer(0, 32'h1001, 0, n, rd, ae, dn_after);
        chk("abort_old", rd, 32'h11111111);

        // Reset during WAIT of a write
        xfer(1, 32'h1002, 32'h22222222, n, rd, ae, dn_after);
        write_q = 1; addr_in = 32'h1002; data_in = 32'h99999999;
        @(negedge clk);
        rst = 1;
        #1;
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_addr", addr_out, 0);
        write_q = 0;
        @(negedge clk);
        rst = 0;
        @(negedge clk);
        xfer(0, 32'h1002, 0, n, rd, ae, dn_after);
        chk("rst_ram2", rd, 32'h22222222);
        xfer(0, 32'h1005, 0, n, rd, ae, dn_after);
        chk("rst_ram5", rd, 32'hDEADBEEF);

        // WAIT_STATES=0 back-to-back reads
        f_read_q = 1; f_addr_in = 32'h1000;
        @(negedge clk);
        chk("f_acc1", f_busy, 1);
        chk("f_dn1_early", f_read_dn, 0);
        @(negedge clk);
        chk("f_dn1", f_read_dn, 1);
        chk("f_addr1", f_addr_out, 32'h1000);
        f_read_q = 0;
        @(negedge clk);
        chk("f_idle", f_busy, 0);
        f_read_q = 1; f_addr_in = 32'h1001;
        @(negedge clk);
        chk("f_acc2", f_busy, 1);
        @(negedge clk);
        chk("f_dn2", f_read_dn, 1);
        chk("f_addr2", f_addr_out, 32'h1001);
        f_read_q = 0;
        @(negedge clk);
        chk("f_dn2_drop", f_read_dn, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
